// File: rtl/memr_rr_arbiter_pkg.sv
// rtl/memr_rr_arbiter_pkg.sv - shared types and constants for the MEMR read-channel arbiter
//   Provides the arbiter state enum, the default timeout and the index-width helper.
package memr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARB      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_XFER     = 2'd3
  } arb_state_e;

  localparam int C_TMO_DEFAULT = 65535;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memr_rr_arbiter_rr_pick.sv
// rtl/memr_rr_arbiter_rr_pick.sv - combinational round-robin selector
//   req_i : request vector
//   ptr_i : index of the last winner; scanning starts at ptr_i+1 with wrap-around
//   gnt_o : one-hot winner, idx_o : winner index, vld_o : any request present
module rr_pick
  import memr_arb_pkg::*;
#(
  parameter int P_N = 4
) (
  input  logic [P_N-1:0]           req_i,
  input  logic [idx_w(P_N)-1:0]    ptr_i,
  output logic [P_N-1:0]           gnt_o,
  output logic [idx_w(P_N)-1:0]    idx_o,
  output logic                     vld_o
);

  localparam int IW = idx_w(P_N);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    // k = P_N wraps back onto ptr_i itself, so a lone requester can win again.
    for (int k = 1; k <= P_N; k++) begin
      j = (int'(ptr_i) + k) % P_N;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/memr_rr_arbiter.sv
// rtl/memr_rr_arbiter.sv - round-robin arbiter sharing one MEMR read channel among P_NREQ requesters
//   Optional feature macro: MEMR_RR_ARBITER_TIMEOUT_EN (burst watchdog, sticky ERR).
//   U_REQ/U_ADR/U_LEN in, U_ACK/U_WREN/U_WEND/U_WDAT out : requester side
//   M_REQ/M_ADR/M_LEN out, M_ACK/M_WREN/M_WEND/M_WDAT in : DDR controller MEMR port
//   GNT_IDX/BUSY/ERR out                                 : status
module memr_rr_arbiter
  import memr_arb_pkg::*;
#(
  parameter int P_NREQ  = 4,
  parameter int P_ADR_W = 32,
  parameter int P_LEN_W = 8,
  parameter int P_DAT_W = 512,
  parameter int P_TMO   = C_TMO_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic [P_NREQ-1:0]           U_REQ,
  input  logic [P_NREQ*P_ADR_W-1:0]   U_ADR,
  input  logic [P_NREQ*P_LEN_W-1:0]   U_LEN,
  output logic [P_NREQ-1:0]           U_ACK,
  output logic [P_NREQ-1:0]           U_WREN,
  output logic [P_NREQ-1:0]           U_WEND,
  output logic [P_DAT_W-1:0]          U_WDAT,
  output logic                        M_REQ,
  output logic [P_ADR_W-1:0]          M_ADR,
  output logic [P_LEN_W-1:0]          M_LEN,
  input  logic                        M_ACK,
  input  logic                        M_WREN,
  input  logic                        M_WEND,
  input  logic [P_DAT_W-1:0]          M_WDAT,
  output logic [idx_w(P_NREQ)-1:0]    GNT_IDX,
  output logic                        BUSY,
  output logic                        ERR
);

  localparam int IW = idx_w(P_NREQ);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, gnt_idx_q, pick_idx;
  logic [P_NREQ-1:0]   gnt_q, pick_gnt;
  logic                pick_vld;
  logic [P_ADR_W-1:0]  m_adr_q;
  logic [P_LEN_W-1:0]  m_len_q;
  logic                m_req_q;
  logic                route;
  logic                tmo_hit;

  rr_pick #(.P_N(P_NREQ)) u_pick (
    .req_i (U_REQ),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // Return data is only routed while a burst is owned.
  assign route = (state_q == ST_WAIT_ACK) || (state_q == ST_XFER);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (|U_REQ) state_d = ST_ARB;
      ST_ARB:      state_d = pick_vld ? ST_WAIT_ACK : ST_IDLE;
      ST_WAIT_ACK: begin
        if (tmo_hit)     state_d = ST_IDLE;
        else if (M_ACK)  state_d = M_WEND ? ST_IDLE : ST_XFER;
      end
      ST_XFER:     if (tmo_hit || M_WEND) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    U_ACK  = (state_q == ST_WAIT_ACK && M_ACK) ? gnt_q : '0;
    U_WREN = (route && M_WREN && !tmo_hit) ? gnt_q : '0;
    U_WEND = (route && (M_WEND || tmo_hit)) ? gnt_q : '0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ptr_q     <= IW'(P_NREQ - 1);
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      m_adr_q   <= '0;
      m_len_q   <= '0;
      m_req_q   <= 1'b0;
    end else begin
      if (state_q == ST_ARB && pick_vld) begin
        gnt_q     <= pick_gnt;
        gnt_idx_q <= pick_idx;
        ptr_q     <= pick_idx;
        m_adr_q   <= U_ADR[pick_idx*P_ADR_W +: P_ADR_W];
        m_len_q   <= U_LEN[pick_idx*P_LEN_W +: P_LEN_W];
        m_req_q   <= 1'b1;
      end else if (state_q == ST_WAIT_ACK && (M_ACK || tmo_hit)) begin
        m_req_q   <= 1'b0;
      end
      // GNT_IDX keeps the last winner for status; only the one-hot is released.
      if (state_q != ST_IDLE && state_d == ST_IDLE) gnt_q <= '0;
    end
  end

  assign U_WDAT  = M_WDAT;
  assign M_REQ   = m_req_q;
  assign M_ADR   = m_adr_q;
  assign M_LEN   = m_len_q;
  assign GNT_IDX = gnt_idx_q;
  assign BUSY    = (state_q != ST_IDLE);

`ifdef MEMR_RR_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(P_TMO);

  logic [15:0] tmo_cnt_q;
  logic        err_q;

  // Cleared while arbitrating so every burst starts from zero; any data beat
  // shows the controller is alive and restarts the window.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == ST_ARB) tmo_cnt_q <= '0;
      else if (route)        tmo_cnt_q <= M_WREN ? 16'd0 : tmo_cnt_q + 16'd1;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign tmo_hit = route && (tmo_cnt_q == TMO_LIM);
  assign ERR     = err_q;
`else
  assign tmo_hit = 1'b0;
  assign ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_memr_rr_arbiter.sv
// tb/tb_memr_rr_arbiter.sv - self-checking bench for memr_rr_arbiter
module tb_memr_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int DW = 32;

  logic            CLK;
  logic            RSTn;
  logic [N-1:0]    U_REQ;
  logic [N*AW-1:0] U_ADR;
  logic [N*LW-1:0] U_LEN;
  logic [N-1:0]    U_ACK, U_WREN, U_WEND;
  logic [DW-1:0]   U_WDAT;
  logic            M_REQ;
  logic [AW-1:0]   M_ADR;
  logic [LW-1:0]   M_LEN;
  logic            M_ACK, M_WREN, M_WEND;
  logic [DW-1:0]   M_WDAT;
  logic [1:0]      GNT_IDX;
  logic            BUSY, ERR;

  memr_rr_arbiter #(
    .P_NREQ(N), .P_ADR_W(AW), .P_LEN_W(LW), .P_DAT_W(DW), .P_TMO(100)
  ) dut (
    .CLK(CLK), .RSTn(RSTn),
    .U_REQ(U_REQ), .U_ADR(U_ADR), .U_LEN(U_LEN),
    .U_ACK(U_ACK), .U_WREN(U_WREN), .U_WEND(U_WEND), .U_WDAT(U_WDAT),
    .M_REQ(M_REQ), .M_ADR(M_ADR), .M_LEN(M_LEN),
    .M_ACK(M_ACK), .M_WREN(M_WREN), .M_WEND(M_WEND), .M_WDAT(M_WDAT),
    .GNT_IDX(GNT_IDX), .BUSY(BUSY), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0]  wren;
    logic [N-1:0]  wend;
    logic [DW-1:0] dat;
  } sb_t;

  typedef struct {
    logic [N-1:0] req;
    int           exp_idx;
  } vec_t;

  sb_t          sb[$];
  sb_t          mon_e;
  vec_t         vecs[11];
  logic [AW-1:0] adr_m[N];
  logic [LW-1:0] len_m[N];
  int           checks = 0;
  int           errors = 0;
  int           n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      U_ADR[i*AW +: AW] = adr_m[i];
      U_LEN[i*LW +: LW] = len_m[i];
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic beat(input int idx, input bit last);
    logic [N-1:0] oh;
    oh     = N'(1) << idx;
    M_WREN = 1'b1;
    M_WEND = last;
    M_WDAT = $urandom;
    sb.push_back('{wren: oh, wend: (last ? oh : '0), dat: M_WDAT});
    @(negedge CLK);
    M_WREN = 1'b0;
    M_WEND = 1'b0;
  endtask

  // Acts as the DDR controller for one burst granted to requester idx.
  task automatic burst(input int idx, input bit same_cycle);
    int k;
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    k  = 0;
    while (M_REQ !== 1'b1 && k < 40) begin
      @(negedge CLK);
      k++;
    end
    chk("m_req_seen", M_REQ, 1);
    chk("m_adr", M_ADR, adr_m[idx]);
    chk("m_len", M_LEN, len_m[idx]);
    chk("gnt_idx", GNT_IDX, idx);
    @(negedge CLK);
    chk("m_req_hold", M_REQ, 1);
    M_ACK = 1'b1;
    if (same_cycle) begin
      M_WREN = 1'b1;
      M_WEND = 1'b1;
      M_WDAT = $urandom;
      sb.push_back('{wren: oh, wend: oh, dat: M_WDAT});
    end
    #1;
    chk("u_ack", U_ACK, oh);
    @(negedge CLK);
    M_ACK  = 1'b0;
    M_WREN = 1'b0;
    M_WEND = 1'b0;
    chk("m_req_drop", M_REQ, 0);
    if (!same_cycle)
      for (int b = 0; b <= int'(len_m[idx]); b++) beat(idx, b == int'(len_m[idx]));
    chk("busy_end", BUSY, 0);
  endtask

  // Scoreboard: every routed strobe must match the next expected beat.
  always @(negedge CLK) begin
    #2;
    if (U_WREN !== '0 || U_WEND !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_strobe wren=%b wend=%b required none", U_WREN, U_WEND);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_wren", U_WREN, mon_e.wren);
        chk("sb_wend", U_WEND, mon_e.wend);
        if (mon_e.wren != '0) chk("sb_wdat", U_WDAT, mon_e.dat);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=stuck required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    RSTn   = 1'b0;
    U_REQ  = '0;
    U_ADR  = '0;
    U_LEN  = '0;
    M_ACK  = 1'b0;
    M_WREN = 1'b0;
    M_WEND = 1'b0;
    M_WDAT = '0;
    for (int i = 0; i < N; i++) begin
      adr_m[i] = 32'hA000_0000 + 32'(i) * 32'h100;
      len_m[i] = LW'(i);
    end
    pack();

    vecs[0]  = '{4'b1111, 0};
    vecs[1]  = '{4'b1111, 1};
    vecs[2]  = '{4'b1111, 2};
    vecs[3]  = '{4'b1111, 3};
    vecs[4]  = '{4'b1111, 0};
    vecs[5]  = '{4'b1010, 1};
    vecs[6]  = '{4'b1010, 3};
    vecs[7]  = '{4'b0001, 0};
    vecs[8]  = '{4'b0001, 0};
    vecs[9]  = '{4'b1100, 2};
    vecs[10] = '{4'b0011, 0};

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_m_req", M_REQ, 0);
    chk("rst_m_adr", M_ADR, 0);
    chk("rst_m_len", M_LEN, 0);
    chk("rst_gnt_idx", GNT_IDX, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR, 0);
    chk("rst_u_ack", U_ACK, 0);
    RSTn = 1'b1;

    // Single requester 2, ADR 0x1000, LEN 3, with request latency
    adr_m[2] = 32'h1000;
    len_m[2] = 8'd3;
    pack();
    @(negedge CLK);
    U_REQ = 4'b0100;
    @(negedge CLK);
    chk("lat_m_req_c1", M_REQ, 0);
    chk("lat_busy_c1", BUSY, 1);
    @(negedge CLK);
    chk("lat_m_req_c2", M_REQ, 1);
    burst(2, 1'b0);
    U_REQ = '0;

    // Round-robin order from reset, then mixed request patterns
    for (int i = 0; i < N; i++) begin
      adr_m[i] = 32'hA000_0000 + 32'(i) * 32'h100;
      len_m[i] = LW'(i);
    end
    pack();
    U_REQ = 4'b1111;
    do_reset();
    for (int v = 0; v < 11; v++) begin
      U_REQ = vecs[v].req;
      burst(vecs[v].exp_idx, 1'b0);
    end
    U_REQ = '0;

    // M_ACK and M_WEND together with LEN 0, then re-grant two cycles later
    U_REQ = 4'b0001;
    burst(0, 1'b1);
    @(negedge CLK);
    chk("regrant_c1", M_REQ, 0);
    @(negedge CLK);
    chk("regrant_c2", M_REQ, 1);
    burst(0, 1'b0);
    U_REQ = '0;

    // Spurious return data while idle
    @(negedge CLK);
    M_WREN = 1'b1;
    M_WEND = 1'b1;
    M_WDAT = $urandom;
    #1;
    chk("idle_wren", U_WREN, 0);
    chk("idle_wend", U_WEND, 0);
    @(negedge CLK);
    M_WREN = 1'b0;
    M_WEND = 1'b0;
    chk("idle_busy", BUSY, 0);
    chk("idle_m_req", M_REQ, 0);

    // Reset mid-burst after 2 of 8 beats
    len_m[2] = 8'd7;
    pack();
    U_REQ = 4'b0100;
    n = 0;
    while (M_REQ !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("mid_m_req", M_REQ, 1);
    @(negedge CLK);
    M_ACK = 1'b1;
    #1;
    chk("mid_u_ack", U_ACK, 4'b0100);
    @(negedge CLK);
    M_ACK = 1'b0;
    U_REQ = '0;
    beat(2, 1'b0);
    beat(2, 1'b0);
    M_WREN = 1'b1;
    M_WDAT = $urandom;
    RSTn   = 1'b0;
    #1;
    chk("mid_rst_wren", U_WREN, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_m_req", M_REQ, 0);
    chk("mid_rst_gnt_idx", GNT_IDX, 0);
    chk("mid_rst_m_adr", M_ADR, 0);
    @(negedge CLK);
    M_WREN = 1'b0;
    U_REQ  = 4'b1111;
    RSTn   = 1'b1;
    burst(0, 1'b0);
    U_REQ = '0;

`ifdef MEMR_RR_ARBITER_TIMEOUT_EN
    // Withheld M_WEND: watchdog ends the burst and latches ERR
    U_REQ = 4'b0010;
    n = 0;
    while (M_REQ !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("tmo_m_req", M_REQ, 1);
    @(negedge CLK);
    M_ACK = 1'b1;
    sb.push_back('{wren: '0, wend: 4'b0010, dat: '0});
    @(negedge CLK);
    M_ACK = 1'b0;
    U_REQ = '0;
    chk("tmo_err_early", ERR, 0);
    n = 0;
    while (BUSY !== 1'b0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("tmo_busy", BUSY, 0);
    chk("tmo_err", ERR, 1);
    chk("tmo_m_req_drop", M_REQ, 0);
    repeat (5) @(negedge CLK);
    chk("tmo_err_sticky", ERR, 1);
    do_reset();
    chk("tmo_err_cleared", ERR, 0);
`endif

    @(negedge CLK);
    @(negedge CLK);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memr_rr_arbiter.md
Name: memr_rr_arbiter

Overview:
- Shares one DDR read channel (MEMR request/ack plus write-back data stream) among P_NREQ read requesters.
- Round-robin grant; the grant is held for one whole burst.
- Sits between the local read engines (playback/DMA readers) and the single MEMR slave port of the DDR controller wrapper.
- Routes the returned data beats and the end-of-burst strobe back to the granted requester only.

Parameters:
- P_NREQ, 4, number of requesters (2..8).
- P_ADR_W, 32, request address width.
- P_LEN_W, 8, burst length width; a request of LEN transfers LEN+1 beats.
- P_DAT_W, 512, data beat width.
- P_TMO, 65535, timeout in CLK cycles (used only with the optional feature).

Ports:
- CLK  in  1  sole clock.
- RSTn  in  1  asynchronous active-low reset.
- U_REQ  in  P_NREQ  per-requester request level; held until its U_ACK.
- U_ADR  in  P_NREQ*P_ADR_W  packed request addresses; slice i belongs to requester i.
- U_LEN  in  P_NREQ*P_LEN_W  packed burst lengths.
- U_ACK  out  P_NREQ  one-cycle accept pulse to the granted requester.
- U_WREN  out  P_NREQ  per-requester data-valid strobe.
- U_WEND  out  P_NREQ  per-requester last-beat strobe.
- U_WDAT  out  P_DAT_W  data, broadcast to all requesters.
- M_REQ  out  1  downstream request level.
- M_ADR  out  P_ADR_W  downstream address.
- M_LEN  out  P_LEN_W  downstream burst length.
- M_ACK  in  1  downstream accept pulse.
- M_WREN  in  1  downstream data valid.
- M_WEND  in  1  downstream last beat (coincident with the final M_WREN).
- M_WDAT  in  P_DAT_W  downstream data.
- GNT_IDX  out  clog2(P_NREQ)  current or last granted index, for status registers.
- BUSY  out  1  high whenever the state is not IDLE.
- ERR  out  1  sticky timeout flag (tied 0 without the optional feature).

Behaviour:
- Reset values: all outputs 0. Round-robin pointer = P_NREQ-1, so requester 0 has first priority. State = IDLE.
- State machine: IDLE -> ARB -> WAIT_ACK -> XFER -> IDLE.
- IDLE: when any U_REQ bit is high, go to ARB.
- ARB (1 cycle):
  - Pick the first asserted U_REQ bit scanning from pointer+1 upward with wrap-around.
  - Register the grant one-hot, GNT_IDX, M_ADR and M_LEN from the granted slice.
  - Update the pointer to the granted index.
  - Next state WAIT_ACK; M_REQ goes high on entering WAIT_ACK.
- WAIT_ACK:
  - M_REQ stays high, with M_ADR and M_LEN stable.
  - On M_ACK: M_REQ drops the next cycle, and U_ACK[gnt] pulses the same cycle as M_ACK (combinational decode of the registered grant).
  - Next state XFER.
- XFER:
  - U_WREN[i] = M_WREN & gnt[i] and U_WEND[i] = M_WEND & gnt[i], combinational with zero latency.
  - U_WDAT = M_WDAT.
  - When M_WEND is seen, go to IDLE; the grant is released the following cycle.
- Latency: U_REQ rising in IDLE gives M_REQ high 2 cycles later. Minimum idle gap between bursts is 2 cycles (IDLE + ARB).
- M_WEND arriving in the same cycle as M_ACK: accepted; go directly to IDLE and pulse both U_ACK and U_WEND.
- M_WREN or M_WEND outside XFER or WAIT_ACK: ignored, never routed to any requester.
- Requester dropping U_REQ while in WAIT_ACK: the request is already committed and completes normally; U_ACK still pulses.
- Single active requester: it is re-granted repeatedly; the pointer may equal its own index.
- RSTn asserted mid-burst: immediate return to IDLE and all outputs 0. The downstream controller must also be reset by the same RSTn.

Optional Feature:
- Macro: MEMR_RR_ARBITER_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to WAIT_ACK and on every M_WREN, and increments in WAIT_ACK and XFER.
  - On reaching P_TMO: set ERR (sticky until RSTn), pulse U_WEND[gnt] once without U_WREN, drop M_REQ, go to IDLE.
- Without the macro: no counter is built, ERR is tied 0, and a hung burst blocks the arbiter indefinitely.

Decomposition:
- Shared package memr_arb_pkg:
  - typedef of the state enum (IDLE, ARB, WAIT_ACK, XFER).
  - localparam function for clog2 of P_NREQ.
  - default P_TMO constant.
- One sub-module, rr_pick: combinational round-robin selector. Inputs are the request vector and the pointer; outputs are the one-hot grant and the index. It is reusable for the REG_BUS master arbiter.

Test Plan:
- Single requester: U_REQ[2]=1, ADR=0x1000, LEN=3. Expect M_REQ 2 cycles later with M_ADR=0x1000, M_LEN=3; U_ACK[2] with M_ACK; 4 U_WREN[2] beats; U_WEND[2] on beat 4; no strobes on other indices.
- All four requesting continuously from reset: grant order 0,1,2,3,0; GNT_IDX follows that sequence; each requester receives only its own beats.
- M_ACK and M_WEND in the same cycle with LEN=0: U_ACK and U_WEND pulse together; BUSY drops the next cycle; the next grant follows 2 cycles later.
- Spurious M_WREN in IDLE: all U_WREN stay 0 and the state is unchanged.
- RSTn pulsed low mid-XFER after 2 of 8 beats: all outputs 0 immediately; the next request is granted to requester 0.
- TIMEOUT_EN build with P_TMO=100 and M_WEND withheld: after 100 idle cycles ERR=1, U_WEND[gnt] pulses with U_WREN=0, the FSM returns to IDLE, and ERR stays 1 until reset.
